// File: rtl/jump_sequencer.sv
// Override sequencer between btn_interface and the traffic-light FSM: minimum green, forced
// yellow, all-red, then a one-cycle target load. Define OVR_COOLDOWN_EN to hold off new requests.

package tl_pkg;
  typedef enum logic [3:0] {
    S0_A_STRAIGHT    = 4'd0,
    S1_A_YELLOW      = 4'd1,
    S2_A_LEFT        = 4'd2,
    S3_A_LEFT_YELLOW = 4'd3,
    S4_B_STRAIGHT    = 4'd4,
    S5_B_YELLOW      = 4'd5,
    S6_B_LEFT        = 4'd6,
    S7_B_LEFT_YELLOW = 4'd7,
    S8_OVERRIDE      = 4'd8
  } state_t;
endpackage

module jump_sequencer
  import tl_pkg::*;
#(
  parameter int unsigned MIN_GREEN_S = 5,
  parameter int unsigned YELLOW_S    = 3,
  parameter int unsigned ALLRED_S    = 2,
  parameter int unsigned COOLDOWN_S  = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   tick_1s,
  input  logic   jump_req,
  input  state_t jump_state,
  input  state_t cur_state,
  input  logic   cur_green,
  output logic   accept_jump,
  output logic   force_yellow,
  output logic   force_allred,
  output logic   load_pulse,
  output state_t load_state,
  output logic   busy
);

  // Phase counter never needs to count past the longest timed phase.
  localparam int unsigned PhMaxYa = (YELLOW_S > ALLRED_S) ? YELLOW_S : ALLRED_S;
  localparam int unsigned PhMax   = (PhMaxYa > COOLDOWN_S) ? PhMaxYa : COOLDOWN_S;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StYellow,
    StAllred,
    StLoad,
    StAck,
    StCool
  } seq_state_e;

  seq_state_e       state_q, state_d;
  state_t           tgt_q, tgt_d;
  state_t           cur_state_q;
  logic [CNT_W-1:0] green_age_q;
  logic [CNT_W-1:0] ph_cnt_q;
  logic             force_yellow_q;
  logic             force_allred_q;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      StIdle: begin
        if (jump_req) begin
          tgt_d = jump_state;
          if (jump_state == S8_OVERRIDE) begin
            state_d = StAck;
          end else if (jump_state == cur_state && cur_green) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Only a green may be cut; FSM-owned yellow/all-red run to completion.
        if (cur_state == tgt_q && cur_green) begin
          state_d = StAck;
        end else if (cur_green && green_age_q >= CNT_W'(MIN_GREEN_S)) begin
          state_d = StYellow;
        end
      end
      StYellow: begin
        if (ph_cnt_q == CNT_W'(YELLOW_S)) state_d = StAllred;
      end
      StAllred: begin
        if (ph_cnt_q == CNT_W'(ALLRED_S)) state_d = StLoad;
      end
      StLoad:   state_d = StCool;
      StAck:    state_d = StCool;
      StCool: begin
`ifdef OVR_COOLDOWN_EN
        if (ph_cnt_q == CNT_W'(COOLDOWN_S)) state_d = StIdle;
`else
        state_d = StIdle;
`endif
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      tgt_q          <= S0_A_STRAIGHT;
      cur_state_q    <= S0_A_STRAIGHT;
      green_age_q    <= '0;
      ph_cnt_q       <= '0;
      force_yellow_q <= 1'b0;
      force_allred_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      cur_state_q <= cur_state;

      if (cur_state != cur_state_q) begin
        green_age_q <= '0;
      end else if (tick_1s && cur_green && green_age_q != '1) begin
        green_age_q <= green_age_q + 1'b1;
      end

      // Cleared on the transition itself, so a tick in that cycle is not counted.
      if (state_d != state_q) begin
        ph_cnt_q <= '0;
      end else if (tick_1s && ph_cnt_q < CNT_W'(PhMax)) begin
        ph_cnt_q <= ph_cnt_q + 1'b1;
      end

      force_yellow_q <= (state_d == StYellow);
      force_allred_q <= (state_d == StAllred);
    end
  end

  assign force_yellow = force_yellow_q;
  assign force_allred = force_allred_q;
  assign load_pulse   = (state_q == StLoad);
  assign accept_jump  = (state_q == StLoad) || (state_q == StAck);
  assign load_state   = tgt_q;
  assign busy         = (state_q != StIdle);

endmodule
